// File: rtl/kpn_pkg.sv
// Shared types and default widths for the KPN multiply/accumulate pipeline.
package kpn_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int KPN_PRODUCT_W = 32;
    localparam int KPN_ACC_W     = 40;

endpackage

// File: rtl/accumulator_module.sv
// Block accumulator: sums BLOCK_LEN products (or up to an entry_last marker)
// and presents each block sum on a valid/ready channel.
module accumulator_module
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_PRODUCT_W,
    parameter int ACC_WIDTH  = KPN_ACC_W,
    parameter int BLOCK_LEN  = 8,
    parameter int CNT_WIDTH  = $clog2(BLOCK_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] entry_1,
    input  logic                  entry_valid,
    input  logic                  entry_last,
    output logic                  entry_ready,
    output logic [ACC_WIDTH-1:0]  output_1,
    output logic [CNT_WIDTH-1:0]  output_count,
    output logic                  output_valid,
    input  logic                  output_ready
);

    generate
        if (BLOCK_LEN < 1 || ACC_WIDTH < DATA_WIDTH + $clog2(BLOCK_LEN)) begin : g_param_check
            $error("accumulator_module: BLOCK_LEN must be >= 1 and ACC_WIDTH >= DATA_WIDTH + clog2(BLOCK_LEN)");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BLOCK_LEN - 1);

    acc_state_t             r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [ACC_WIDTH-1:0]   r_out;
    logic [CNT_WIDTH-1:0]   r_out_cnt;
    logic                   r_out_vld;

    logic                   w_accept;
    logic                   w_take;
    logic                   w_close;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;

    // A pending result only blocks input when downstream is not draining it.
    assign entry_ready  = (r_state == ACCUM) | output_ready;
    assign output_1     = r_out;
    assign output_count = r_out_cnt;
    assign output_valid = r_out_vld;

    assign w_accept  = entry_valid & entry_ready;
    assign w_take    = r_out_vld & output_ready;
    assign w_close   = w_accept & ((r_cnt == LAST_CNT) | entry_last);
    assign w_sum     = r_acc + ACC_WIDTH'(entry_1);
    assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_out_cnt <= '0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_close) begin
                r_out     <= w_sum;
                r_out_cnt <= w_cnt_inc;
                r_out_vld <= 1'b1;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_state   <= HOLD;
            end else begin
                if (w_accept) begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_inc;
                end
                // Result drained with no new close: back to accumulating.
                if (w_take) begin
                    r_out_vld <= 1'b0;
                    r_state   <= ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_accumulator_module.sv
// Self-checking bench: block-level scoreboard model plus directed literal checks
// and a randomized traffic phase.
module tb_accumulator_module;

    localparam int DW = 32;
    localparam int AW = 40;
    localparam int BL = 8;
    localparam int CW = $clog2(BL + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] entry_1 = '0;
    logic          entry_valid = 1'b0;
    logic          entry_last = 1'b0;
    logic          entry_ready;
    logic [AW-1:0] output_1;
    logic [CW-1:0] output_count;
    logic          output_valid;
    logic          output_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    accumulator_module #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .BLOCK_LEN(BL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .entry_1(entry_1), .entry_valid(entry_valid), .entry_last(entry_last),
        .entry_ready(entry_ready),
        .output_1(output_1), .output_count(output_count), .output_valid(output_valid),
        .output_ready(output_ready)
    );

    always #5 clk = ~clk;

    // Model: products of the open block, and finished block results not yet taken.
    typedef struct {
        logic [AW-1:0] sum;
        int            n;
    } res_t;

    logic [AW-1:0] part[$];
    res_t          exp_q[$];

    function automatic logic [AW-1:0] part_sum();
        logic [AW-1:0] s = '0;
        foreach (part[i]) s = s + part[i];
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            part.delete();
            exp_q.delete();
        end else if (entry_valid && (exp_q.size() == 0 || output_ready)) begin
            part.push_back(AW'(entry_1));
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (entry_last || part.size() == BL) begin
                exp_q.push_back('{sum: part_sum(), n: part.size()});
                part.delete();
            end
        end else if (exp_q.size() != 0 && output_ready) begin
            void'(exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (entry_ready !== (exp_q.size() == 0 || output_ready)) begin
                errors++;
                $display("FAIL entry_ready t=%0t got=%b exp=%b", $time, entry_ready, (exp_q.size() == 0 || output_ready));
            end
            checks++;
            if (output_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL output_valid t=%0t got=%b exp=%b", $time, output_valid, (exp_q.size() != 0));
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (output_1 !== exp_q[0].sum || output_count !== CW'(exp_q[0].n)) begin
                    errors++;
                    $display("FAIL result t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                             output_1, output_count, exp_q[0].sum, exp_q[0].n);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input logic last);
        bit rdy;
        int cyc = 0;
        entry_1     = d;
        entry_last  = last;
        entry_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = entry_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!rdy && cyc < 100);
        if (!rdy) begin
            errors++;
            checks++;
            $display("FAIL send_timeout got=not_ready exp=accept");
        end
        entry_valid = 1'b0;
        entry_last  = 1'b0;
    endtask

    // Next negedge after a closing accept: result must be present now.
    task automatic expect_out(input string name, input logic [AW-1:0] s, input int n);
        @(negedge clk);
        chk({name, "_valid"}, 64'(output_valid), 64'd1);
        chk({name, "_sum"}, 64'(output_1), 64'(s));
        chk({name, "_cnt"}, 64'(output_count), 64'(n));
        if (exp_q.size() != 0) chk({name, "_model"}, 64'(exp_q[0].sum), 64'(s));
        else chk({name, "_model_empty"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", 64'(entry_ready), 64'd1);
        chk("rst_valid", 64'(output_valid), 64'd0);
        chk("rst_sum", 64'(output_1), 64'd0);
        chk("rst_cnt", 64'(output_count), 64'd0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(entry_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic block: valid for exactly one cycle
        for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0);
        expect_out("basic", 40'd36, 8);
        @(negedge clk);
        chk("basic_one_cycle", 64'(output_valid), 64'd0);
        @(posedge clk);
        #1;

        // Maximum values
        for (int i = 0; i < 8; i++) send(32'hFFFF_FFFF, 1'b0);
        expect_out("max", 40'h07_FFFF_FFF8, 8);

        // Early close then a fresh block
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd30, 1'b1);
        expect_out("early", 40'd60, 3);
        for (int i = 0; i < 8; i++) send(32'd5, 1'b0);
        expect_out("after_early", 40'd40, 8);

        // Backpressure
        output_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'd2, 1'b0);
        entry_1 = 32'd7;
        entry_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_sum", 64'(output_1), 64'd16);
            chk("bp_ready", 64'(entry_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        output_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(entry_ready), 64'd1);
        @(posedge clk);
        #1;
        entry_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid_drop", 64'(output_valid), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) send(32'd7, 1'b0);
        expect_out("bp_next", 40'd56, 8);

        // Reset mid-block
        for (int i = 0; i < 4; i++) send(32'd100, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) send(32'd1, 1'b0);
        expect_out("mid_reset", 40'd8, 8);

        // Bubbles
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(32'd3, 1'b0);
        end
        expect_out("bubbles", 40'd24, 8);

        // Randomized traffic checked by the scoreboard every cycle
        for (int c = 0; c < 2000; c++) begin
            entry_valid  = ($urandom_range(0, 9) < 7);
            entry_last   = ($urandom_range(0, 9) == 0);
            entry_1      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : DW'($urandom);
            output_ready = ($urandom_range(0, 9) < 7);
            reset        = (c == 1000);
            @(posedge clk);
            #1;
        end
        entry_valid  = 1'b0;
        entry_last   = 1'b0;
        reset        = 1'b0;
        output_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
